// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg7_pkg;

    localparam int DISP_W               = 32;
    localparam int MAX_REQ              = 8;
    localparam int OWNER_W              = 3;
    localparam int DEFAULT_DWELL_CYCLES = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SHOW = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_display_arbiter_if.sv
// Requester bus, pin control and display-driver write port of the arbiter.
interface seg7_display_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import seg7_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [DISP_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      pin_en;
    logic [OWNER_W-1:0]        pin_sel;
    logic                      disp_cs;
    logic [DISP_W-1:0]         disp_data;

    modport master (
        output req, req_data, pin_en, pin_sel,
        input  ack, disp_cs, disp_data
    );

    modport slave (
        input  req, req_data, pin_en, pin_sel,
        output ack, disp_cs, disp_data
    );

endinterface

// File: rtl/seg7_display_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grant and wraps.
module rr_arbiter
    import seg7_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [OWNER_W-1:0] last,
    output logic [NUM_REQ-1:0] grant,
    output logic [OWNER_W-1:0] grant_idx,
    output logic               grant_valid
);

    // Rank r is the r-th position after the last grant; the lowest eligible rank wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_valid && elig[i] && (((int'(last) + 1 + r) % NUM_REQ) == i)) begin
                    grant[i]    = 1'b1;
                    grant_idx   = OWNER_W'(i);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Shares one 8-digit seven-segment display among NUM_REQ requesters with
// round-robin dwell windows, in-window refresh and pinning to a single requester.
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
    parameter int CNT_W        = 26
) (
    input  logic                 clock,
    input  logic                 rst,
    seg7_display_arbiter_if.slave bus,
    output logic [OWNER_W-1:0]   owner,
    output logic                 busy
);

    state_e              state_q, state_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [OWNER_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                disp_cs_q, disp_cs_d;
    logic [DISP_W-1:0]   disp_data_q, disp_data_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  elig, arb_elig, owner_oh, grant_oh;
    logic [OWNER_W-1:0]  grant_idx;
    logic                grant_valid;
    logic [DISP_W-1:0]   grant_word, owner_word;
    logic                expired, preempt, refresh;

    // Pinning narrows eligibility to pin_sel; an out-of-range pin_sel matches nobody.
    always_comb begin
        elig       = '0;
        owner_oh   = '0;
        owner_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i]     = bus.req[i] && (!bus.pin_en || (bus.pin_sel == OWNER_W'(i)));
            owner_oh[i] = (owner_q == OWNER_W'(i));
            if (owner_q == OWNER_W'(i)) owner_word = bus.req_data[DISP_W*i +: DISP_W];
        end
    end

    // While showing, the owner is excluded so a grant means a genuine switch.
    assign arb_elig = (state_q == ST_SHOW) ? (elig & ~owner_oh) : elig;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .elig        (arb_elig),
        .last        (last_q),
        .grant       (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) grant_word = bus.req_data[DISP_W*i +: DISP_W];
        end
    end

    assign expired = (cnt_q == CNT_W'(DWELL_CYCLES - 1));
    assign preempt = bus.pin_en && (bus.pin_sel != owner_q);
    // A req still high in its own ack cycle is the old word, not a new write.
    assign refresh = |(bus.req & owner_oh & ~ack_q);

    // NOTE: every _d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        disp_cs_d   = 1'b0;
        disp_data_d = disp_data_q;
        ack_d       = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d     = ST_LOAD;
                    owner_d     = grant_idx;
                    last_d      = grant_idx;
                    disp_cs_d   = 1'b1;
                    disp_data_d = grant_word;
                    ack_d       = grant_oh;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHOW;
                cnt_d   = '0;
            end
            ST_SHOW: begin
                cnt_d = cnt_q + 1'b1;
                if (preempt) begin
                    state_d = ST_IDLE;
                end else if (expired && grant_valid) begin
                    state_d     = ST_LOAD;
                    owner_d     = grant_idx;
                    last_d      = grant_idx;
                    disp_cs_d   = 1'b1;
                    disp_data_d = grant_word;
                    ack_d       = grant_oh;
                end else begin
                    if (expired) cnt_d = '0;
                    if (refresh) begin
                        disp_cs_d   = 1'b1;
                        disp_data_d = owner_word;
                        ack_d       = owner_oh;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            last_q      <= OWNER_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            disp_cs_q   <= 1'b0;
            disp_data_q <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            disp_cs_q   <= disp_cs_d;
            disp_data_q <= disp_data_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.disp_cs   = disp_cs_q;
    assign bus.disp_data = disp_data_q;
    assign owner         = owner_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with a 16-cycle dwell window.
module tb_seg7_display_arbiter;
    import seg7_pkg::*;

    logic              clock;
    logic              rst;
    logic [OWNER_W-1:0] owner;
    logic              busy;
    int                n_checks = 0;
    int                n_fail   = 0;

    seg7_display_arbiter_if #(.NUM_REQ(4)) bus ();

    seg7_display_arbiter #(
        .NUM_REQ      (4),
        .DWELL_CYCLES (16),
        .CNT_W        (5)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus),
        .owner (owner),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        bus.req_data[32*i +: 32] = w;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.req     = '0;
        bus.pin_en  = 1'b0;
        bus.pin_sel = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_and_single();
        do_reset();
        check("rst_cs", bus.disp_cs, 0);
        check("rst_data", bus.disp_data, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_owner", owner, 0);
        check("rst_busy", busy, 0);

        set_word(2, 32'h1234_ABCD);
        bus.req = 4'b0100;
        tick();
        check("single_cs", bus.disp_cs, 1);
        check("single_data", bus.disp_data, 32'h1234_ABCD);
        check("single_ack", bus.ack, 4'b0100);
        check("single_owner", owner, 2);
        check("single_busy", busy, 1);
        bus.req = '0;
        tick();
        check("single_cs_drop", bus.disp_cs, 0);
        check("single_ack_drop", bus.ack, 0);
        check("single_data_hold", bus.disp_data, 32'h1234_ABCD);

        repeat (3) tick();
        set_word(2, 32'h5555_5555);
        bus.req = 4'b0100;
        rst     = 1'b1;
        #1;
        check("midrst_cs", bus.disp_cs, 0);
        check("midrst_data", bus.disp_data, 0);
        check("midrst_owner", owner, 0);
        check("midrst_busy", busy, 0);
        tick();
        check("midrst_ack", bus.ack, 0);
        rst     = 1'b0;
        bus.req = '0;
        tick();
        check("postrst_ack", bus.ack, 0);
        check("postrst_cs", bus.disp_cs, 0);
    endtask

    task automatic test_round_robin();
        int               exp_seq[5];
        int               n_grants;
        int               last_c;
        logic [OWNER_W-1:0] prev_owner;
        logic [3:0]       oh;
        exp_seq  = '{0, 1, 2, 3, 0};
        n_grants = 0;
        last_c   = 0;
        prev_owner = '0;
        do_reset();
        for (int i = 0; i < 4; i++) set_word(i, 32'hA000_0000 + i);
        bus.req = 4'hF;
        for (int c = 0; c < 120 && n_grants < 5; c++) begin
            tick();
            if (bus.disp_cs && (n_grants == 0 || owner != prev_owner)) begin
                oh = 4'b0001 << exp_seq[n_grants];
                check("rr_owner", owner, exp_seq[n_grants]);
                check("rr_ack", bus.ack, oh);
                check("rr_data", bus.disp_data, 32'hA000_0000 + exp_seq[n_grants]);
                if (n_grants > 0) check("rr_gap", c - last_c, 17);
                last_c     = c;
                prev_owner = owner;
                n_grants++;
            end
            bus.req = 4'hF & ~bus.ack;
        end
        check("rr_grants", n_grants, 5);
        bus.req = '0;
    endtask

    task automatic test_refresh_vs_expiry();
        logic seen;
        do_reset();
        set_word(1, 32'h1111_0001);
        bus.req = 4'b0010;
        tick();
        check("rf_grant_owner", owner, 1);
        check("rf_grant_ack", bus.ack, 4'b0010);
        bus.req = '0;
        repeat (5) tick();
        set_word(1, 32'h1111_0002);
        bus.req[1] = 1'b1;
        tick();
        check("rf_refresh_cs", bus.disp_cs, 1);
        check("rf_refresh_ack", bus.ack, 4'b0010);
        check("rf_refresh_data", bus.disp_data, 32'h1111_0002);
        bus.req[1] = 1'b0;
        tick();
        check("rf_refresh_single", bus.disp_cs, 0);
        set_word(3, 32'h3333_0003);
        bus.req[3] = 1'b1;
        repeat (9) tick();
        check("rf_wait_owner", owner, 1);
        check("rf_wait_cs", bus.disp_cs, 0);
        set_word(1, 32'h1111_0003);
        bus.req[1] = 1'b1;
        tick();
        check("rf_switch_cs", bus.disp_cs, 1);
        check("rf_switch_owner", owner, 3);
        check("rf_switch_ack", bus.ack, 4'b1000);
        check("rf_switch_data", bus.disp_data, 32'h3333_0003);
        bus.req[3] = 1'b0;
        seen = 1'b0;
        repeat (16) begin
            tick();
            seen |= bus.ack[1];
        end
        check("rf_pending_unacked", seen, 0);
        tick();
        check("rf_next_turn_owner", owner, 1);
        check("rf_next_turn_ack", bus.ack, 4'b0010);
        check("rf_next_turn_data", bus.disp_data, 32'h1111_0003);
        bus.req = '0;
    endtask

    task automatic test_pin();
        logic seen;
        do_reset();
        set_word(0, 32'h0000_00A0);
        bus.req = 4'b0001;
        tick();
        check("pin_first_owner", owner, 0);
        bus.req = '0;
        tick();
        bus.pin_en  = 1'b1;
        bus.pin_sel = 3'd3;
        set_word(0, 32'h0000_00A1);
        bus.req[0] = 1'b1;
        tick();
        check("pin_preempt_busy", busy, 0);
        check("pin_preempt_cs", bus.disp_cs, 0);
        check("pin_preempt_ack", bus.ack, 0);
        check("pin_keep_word", bus.disp_data, 32'h0000_00A0);
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen |= bus.ack[0] | bus.disp_cs;
        end
        check("pin_req0_blocked", seen, 0);
        set_word(3, 32'h3333_00B3);
        bus.req[3] = 1'b1;
        tick();
        check("pin_grant_cs", bus.disp_cs, 1);
        check("pin_grant_owner", owner, 3);
        check("pin_grant_ack", bus.ack, 4'b1000);
        check("pin_grant_data", bus.disp_data, 32'h3333_00B3);
        bus.req[3]  = 1'b0;
        bus.pin_sel = 3'd5;
        tick();
        set_word(3, 32'h3333_00B4);
        bus.req[3] = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen |= bus.disp_cs | (|bus.ack);
        end
        check("pin_oob_no_grant", seen, 0);
        check("pin_oob_idle", busy, 0);
        bus.pin_en = 1'b0;
        tick();
        check("unpin_owner", owner, 0);
        check("unpin_ack", bus.ack, 4'b0001);
        check("unpin_data", bus.disp_data, 32'h0000_00A1);
        bus.req = '0;
    endtask

    task automatic test_hold();
        logic seen;
        do_reset();
        set_word(2, 32'h2222_0001);
        bus.req = 4'b0100;
        tick();
        check("hold_grant_owner", owner, 2);
        bus.req = '0;
        seen = 1'b0;
        repeat (16) begin
            tick();
            seen |= bus.disp_cs;
        end
        check("hold_no_cs", seen, 0);
        tick();
        check("hold_expiry_cs", bus.disp_cs, 0);
        check("hold_expiry_owner", owner, 2);
        check("hold_expiry_busy", busy, 1);
        set_word(0, 32'h0000_0C00);
        bus.req[0] = 1'b1;
        repeat (15) tick();
        check("hold_wrap_not_early", bus.disp_cs, 0);
        check("hold_wrap_owner", owner, 2);
        tick();
        check("hold_wrap_switch_cs", bus.disp_cs, 1);
        check("hold_wrap_switch_owner", owner, 0);
        check("hold_wrap_switch_ack", bus.ack, 4'b0001);
        bus.req = '0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.pin_en   = 1'b0;
        bus.pin_sel  = '0;
        test_reset_and_single();
        test_round_robin();
        test_refresh_vs_expiry();
        test_pin();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
